// File: rtl/mem_responder_6502.sv
// Memory-side bus responder for the 6502 core: decodes a RAM window at BASE and stretches reads with RDY.
// Define MEM_RESP_6502_WP_EN to drop writes at offsets >= WP_START and pulse wp_err instead.
module mem_responder_6502 #(
  parameter int unsigned ADDR_W      = 12,
  parameter logic [15:0] BASE        = 16'h0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned WP_START    = 'hC00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rvalid,
  output logic        rdy,
  output logic        wp_err
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [31:0] LOW_MASK = (32'd1 << ADDR_W) - 32'd1;
  localparam logic [15:0] WIN_MASK = ~LOW_MASK[15:0];
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef MEM_RESP_6502_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] lat_off, lat_off_nxt;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] rd_off;
  logic              rd_en;
  logic              ram_we;
  logic              rvalid_nxt;
  logic              wp_err_nxt;
  logic              hit;
  logic              wp_blk;

  logic [7:0] ram [DEPTH];

  assign offset = addr[ADDR_W-1:0];
  assign hit    = req && ((addr & WIN_MASK) == (BASE & WIN_MASK));
  assign wp_blk = WP_EN && (32'(offset) >= WP_START);

  // RESP behaves like IDLE for new requests so back-to-back reads see no bubble
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    lat_off_nxt = lat_off;
    rd_en       = 1'b0;
    rd_off      = offset;
    ram_we      = 1'b0;
    rvalid_nxt  = 1'b0;
    wp_err_nxt  = 1'b0;
    case (state)
      S_IDLE, S_RESP: begin
        state_nxt = S_IDLE;
        if (hit && rw) begin
          if (WAIT_STATES == 0) begin
            rd_en      = 1'b1;
            rvalid_nxt = 1'b1;
          end else begin
            cnt_nxt     = CNT_INIT;
            lat_off_nxt = offset;
            state_nxt   = S_WAIT;
          end
        end else if (hit && !rw) begin
          if (wp_blk) begin
            wp_err_nxt = 1'b1;
          end else begin
            ram_we = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          rd_en      = 1'b1;
          rd_off     = lat_off;
          rvalid_nxt = 1'b1;
          state_nxt  = S_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      lat_off <= '0;
      rdata   <= 8'h00;
      rvalid  <= 1'b0;
      rdy     <= 1'b1;
      wp_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      lat_off <= lat_off_nxt;
      rvalid  <= rvalid_nxt;
      rdy     <= (state_nxt != S_WAIT);
      wp_err  <= wp_err_nxt;
      if (rd_en) begin
        rdata <= ram[rd_off];
      end
    end
  end

  // RAM contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[offset] <= wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder_6502.sv
// Scoreboard bench: one zero-wait responder at 0x0000 and one three-wait responder at 0x2000.
module tb_mem_responder_6502;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, rw0, req3, rw3;
  logic [15:0] addr0, addr3;
  logic [7:0]  wdata0, wdata3;
  logic [7:0]  rdata0, rdata3;
  logic        rvalid0, rvalid3, rdy0, rdy3, wp_err0, wp_err3;

  int checks = 0;
  int errors = 0;
  int lows;
  logic [7:0] q0[$];
  logic [7:0] q3[$];
  logic [7:0] e0, e3;

  always #5 clk = ~clk;

  mem_responder_6502 #(.ADDR_W(12), .BASE(16'h0000), .WAIT_STATES(0), .WP_START('hC00)) u0 (
    .clk(clk), .reset(reset), .req(req0), .rw(rw0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .rvalid(rvalid0), .rdy(rdy0), .wp_err(wp_err0)
  );

  mem_responder_6502 #(.ADDR_W(12), .BASE(16'h2000), .WAIT_STATES(3), .WP_START('hC00)) u3 (
    .clk(clk), .reset(reset), .req(req3), .rw(rw3), .addr(addr3), .wdata(wdata3),
    .rdata(rdata3), .rvalid(rvalid3), .rdy(rdy3), .wp_err(wp_err3)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // one bus cycle on the zero-wait instance; d doubles as the expected read data
  task automatic applyStimulus(input logic is_read, input logic [15:0] a, input logic [7:0] d,
                               input bit exp_hit);
    req0 = 1'b1;
    rw0 = is_read;
    addr0 = a;
    wdata0 = d;
    if (is_read && exp_hit) q0.push_back(d);
    @(posedge clk);
    #1;
    req0 = 1'b0;
  endtask

  task automatic write3(input logic [15:0] a, input logic [7:0] d);
    req3 = 1'b1;
    rw3 = 1'b0;
    addr3 = a;
    wdata3 = d;
    @(posedge clk);
    #1;
    req3 = 1'b0;
  endtask

  // returns at the falling edge of the response cycle with req still held
  task automatic readWaited(input logic [15:0] a, input logic [7:0] exp, output int n_low);
    bit done;
    req3 = 1'b1;
    rw3 = 1'b1;
    addr3 = a;
    @(posedge clk);
    q3.push_back(exp);
    n_low = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (rdy3) done = 1'b1;
      else n_low++;
    end
    checkOutput("rdy3_timeout", done, 1'b1);
    checkOutput("rvalid3_resp", rvalid3, 1'b1);
  endtask

  always @(negedge clk) begin
    if (!reset && rvalid0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("[TB] FAIL rvalid0_unexpected: got rvalid with data %02h, required no response", rdata0);
      end else begin
        e0 = q0.pop_front();
        if (rdata0 !== e0) begin
          errors++;
          $display("[TB] FAIL rdata0: got %02h, required %02h", rdata0, e0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && rvalid3) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("[TB] FAIL rvalid3_unexpected: got rvalid with data %02h, required no response", rdata3);
      end else begin
        e3 = q3.pop_front();
        if (rdata3 !== e3) begin
          errors++;
          $display("[TB] FAIL rdata3: got %02h, required %02h", rdata3, e3);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    req0 = 1'b0; rw0 = 1'b1; addr0 = '0; wdata0 = '0;
    req3 = 1'b0; rw3 = 1'b1; addr3 = '0; wdata3 = '0;
    #1;
    checkOutput("rst_rdy0", rdy0, 1'b1);
    checkOutput("rst_rvalid0", rvalid0, 1'b0);
    checkOutput("rst_rdata0", rdata0, 8'h00);
    checkOutput("rst_wp_err0", wp_err0, 1'b0);
    checkOutput("rst_rdy3", rdy3, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] zero-wait write then read");
    applyStimulus(1'b0, 16'h0003, 8'hA5, 1'b1);
    checkOutput("rvalid0_after_write", rvalid0, 1'b0);
    applyStimulus(1'b1, 16'h0003, 8'hA5, 1'b1);
    checkOutput("rvalid0_after_read", rvalid0, 1'b1);
    checkOutput("rdy0_after_read", rdy0, 1'b1);

    $display("[TB] back-to-back reads and window edge");
    applyStimulus(1'b0, 16'h0010, 8'h31, 1'b1);
    applyStimulus(1'b0, 16'h0011, 8'h32, 1'b1);
    applyStimulus(1'b0, 16'h0012, 8'h33, 1'b1);
    applyStimulus(1'b0, 16'h0FFF, 8'hE7, 1'b1);
    applyStimulus(1'b1, 16'h0010, 8'h31, 1'b1);
    applyStimulus(1'b1, 16'h0011, 8'h32, 1'b1);
    applyStimulus(1'b1, 16'h0012, 8'h33, 1'b1);
    applyStimulus(1'b1, 16'h0FFF, 8'hE7, 1'b1);

    $display("[TB] misses outside the window");
    applyStimulus(1'b0, 16'h1003, 8'hFF, 1'b0);
    checkOutput("rdy0_miss_write", rdy0, 1'b1);
    applyStimulus(1'b1, 16'h1003, 8'h00, 1'b0);
    checkOutput("rvalid0_miss_read", rvalid0, 1'b0);
    applyStimulus(1'b0, 16'hF003, 8'hEE, 1'b0);
    applyStimulus(1'b1, 16'h0003, 8'hA5, 1'b1);

    $display("[TB] read-after-write overwrite");
    applyStimulus(1'b0, 16'h0003, 8'h5A, 1'b1);
    applyStimulus(1'b1, 16'h0003, 8'h5A, 1'b1);

    $display("[TB] protected range");
    applyStimulus(1'b0, 16'h0BFF, 8'h77, 1'b1);
    checkOutput("wp_err0_bff", wp_err0, 1'b0);
    applyStimulus(1'b0, 16'h0C00, 8'h11, 1'b1);
`ifdef MEM_RESP_6502_WP_EN
    checkOutput("wp_err0_c00", wp_err0, 1'b1);
`else
    checkOutput("wp_err0_c00", wp_err0, 1'b0);
    applyStimulus(1'b1, 16'h0C00, 8'h11, 1'b1);
`endif
    applyStimulus(1'b1, 16'h0BFF, 8'h77, 1'b1);
    checkOutput("wp_err0_idle", wp_err0, 1'b0);

    $display("[TB] three wait states");
    write3(16'h2000, 8'h5C);
    write3(16'h2001, 8'hC3);
    checkOutput("rdy3_write", rdy3, 1'b1);
    readWaited(16'h2000, 8'h5C, lows);
    checkOutput("rdy3_low_cycles", lows, 3);
    readWaited(16'h2001, 8'hC3, lows);
    checkOutput("rdy3_low_no_bubble", lows, 3);
    req3 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rdy3_after_resp", rdy3, 1'b1);
    checkOutput("rvalid3_after_resp", rvalid3, 1'b0);

    $display("[TB] reset during wait");
    req3 = 1'b1;
    rw3 = 1'b1;
    addr3 = 16'h2001;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_rdy3", rdy3, 1'b1);
    checkOutput("midrst_rvalid3", rvalid3, 1'b0);
    checkOutput("midrst_rdata3", rdata3, 8'h00);
    checkOutput("midrst_rdata0", rdata0, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    req3 = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("rvalid3_aborted", rvalid3, 1'b0);
    readWaited(16'h2000, 8'h5C, lows);
    checkOutput("rdy3_low_after_rst", lows, 3);
    req3 = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("q0_drained", q0.size(), 0);
    checkOutput("q3_drained", q3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
